float_a_fijo: RTL and testbench
===============================

FLOAT_A_FIJO -- requirements
Module: float_a_fijo

Interface
REQ-001 Parameter: FRAC_BITS, default 4, number of fraction bits of the signed 8-bit fixed-point result; legal range 0..7.
REQ-002 Port: aclk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: areset  in  1  reset, synchronous and active-high.
REQ-004 Port: s_axis_a_tvalid  in  1  upstream beat valid.
REQ-005 Port: s_axis_a_tready  out  1  block accepts a beat this cycle.
REQ-006 Port: s_axis_a_tdata  in  16  IEEE-754 binary16 operand (sign[15], exponent[14:10], mantissa[9:0]).
REQ-007 Port: m_axis_result_tvalid  out  1  result beat valid.
REQ-008 Port: m_axis_result_tready  in  1  downstream accepts the result beat.
REQ-009 Port: m_axis_result_tdata  out  8  signed two's-complement fixed-point result with FRAC_BITS fraction bits.
REQ-010 Port: m_axis_status_tdata  out  2  bit0 = overflow (saturated), bit1 = invalid (NaN); present only per REQ-027.

Function
REQ-011 A beat SHALL transfer on any edge where tvalid and tready are both high, on either interface.
REQ-012 Datapath SHALL be a two-stage elastic pipeline: stage 1 unpacks and shifts; stage 2 rounds, saturates and drives the outputs.
REQ-013 Latency SHALL be exactly 2 cycles from input acceptance to m_axis_result_tvalid high when no backpressure is applied; throughput SHALL be 1 beat/cycle.
REQ-014 Readiness rule: ready2 = !valid2 | m_axis_result_tready; ready1 = !valid1 | ready2; s_axis_a_tready = ready1.
REQ-015 Stalled output SHALL hold m_axis_result_tdata and status stable while tvalid is high and tready is low.
REQ-016 Beats SHALL emerge in acceptance order, with none dropped or duplicated; at most 2 beats are in flight.
REQ-017 Result SHALL equal round((-1)^s x 1.m x 2^(e-15) x 2^FRAC_BITS), rounding to nearest with ties away from zero.
REQ-018 Rounding is applied to magnitude before negation.
REQ-019 Exponent 0 (zero or subnormal) SHALL yield 0x00, including negative zero.
REQ-020 Positive rounded magnitude above 127 and +infinity SHALL saturate to 0x7F with overflow set.
REQ-021 Negative rounded magnitude above 128 and -infinity SHALL saturate to 0x80 with overflow set; a magnitude of exactly 128 SHALL give 0x80 with overflow clear.
REQ-022 NaN (exponent 31, mantissa nonzero) SHALL yield 0x00 with invalid set and overflow clear.
REQ-023 Internal shift width SHALL be sufficient that no intermediate truncation occurs before the saturation decision.

Reset
REQ-024 While areset is high at an edge, valid1, valid2 and m_axis_result_tvalid SHALL clear to 0; m_axis_result_tdata and status SHALL clear to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight beats without emitting them; s_axis_a_tready SHALL read 1 from the first cycle after reset deasserts.
REQ-026 s_axis_a_tready MAY be high during reset; beats offered during reset are not accepted.

Configuration
REQ-027 Macro FLOAT_A_FIJO_STATUS_EN defined: port m_axis_status_tdata and its pipeline flags exist, and the flags travel aligned with their data beat. Macro undefined: the port and flag logic are absent, and data behaviour is identical.

Verification
REQ-028 FRAC_BITS=4, tready=1; inputs 0x3C00, 0x4000, 0xC400 back-to-back -> outputs 0x10, 0x20, 0xC0 on consecutive cycles, the first 2 cycles after acceptance.
REQ-029 Inputs 0x2C00, 0x2800, 0xA800, 0x8000 -> outputs 0x01, 0x01, 0xFF, 0x00.
REQ-030 Inputs 0x4900, 0x7C00, 0xCC00, 0xC800 -> outputs 0x7F, 0x7F, 0x80, 0x80; overflow = 1, 1, 1, 0.
REQ-031 Input 0x7E00 -> output 0x00 with invalid = 1.
REQ-032 m_axis_result_tready held 0 while 3 beats are offered -> 2 beats accepted, then s_axis_a_tready = 0 and output held stable; on release all 3 beats arrive in order with no gaps.
REQ-033 areset pulsed for 1 cycle with 2 beats in flight -> m_axis_result_tvalid = 0 on the next cycle; neither discarded beat ever appears.

Source files
------------

// File: rtl/float_a_fijo.sv
// -----------------------------------------------------------------------------
// float_a_fijo
//
// Converts an IEEE-754 binary16 operand into a signed 8-bit two's-complement
// fixed-point value with FRAC_BITS fraction bits. Rounding is to nearest with
// ties away from zero, applied to the magnitude before negation. Out-of-range
// values and infinities saturate; NaN yields zero. Zero and subnormals give 0.
//
// The datapath is a two-stage elastic pipeline with AXI-Stream style
// handshakes:
//   stage 1: unpack the operand and shift the mantissa into a wide magnitude
//   stage 2: round, saturate and drive the registered outputs
//
// Parameters
//   FRAC_BITS             fraction bits of the result (0..7)
//
// Ports
//   aclk                  clock, rising edge
//   areset                synchronous active-high reset
//   s_axis_a_tvalid       input beat valid
//   s_axis_a_tready       block can accept a beat this cycle
//   s_axis_a_tdata[15:0]  binary16 operand
//   m_axis_result_tvalid  result beat valid
//   m_axis_result_tready  downstream accepts the result beat
//   m_axis_result_tdata   signed fixed-point result [7:0]
//   m_axis_status_tdata   {invalid, overflow}; only when the build macro
//                         FLOAT_A_FIJO_STATUS_EN is defined
// -----------------------------------------------------------------------------
module float_a_fijo #(
    parameter int FRAC_BITS = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [15:0] s_axis_a_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready,
    output logic [7:0]  m_axis_result_tdata
`ifdef FLOAT_A_FIJO_STATUS_EN
    ,
    output logic [1:0]  m_axis_status_tdata
`endif
);

    // Magnitude is held in half-units (one extra LSB below the result LSB) so
    // rounding can be done by a single add. The largest finite operand with
    // FRAC_BITS=7 shifts the 11-bit mantissa left by 13, giving 24 bits; one
    // more bit keeps the rounding add from wrapping.
    localparam int MAG_W = 25;

    // Exponent bias (15) plus mantissa fraction width (10), minus one for the
    // extra half-unit bit kept below the result LSB.
    localparam int SHIFT_OFFSET = 24;

    // Saturate to +max / -max and the result with flags packed as
    // {invalid, overflow, data[7:0]}.
    function automatic logic [9:0] round_saturate(
        input logic             sign,
        input logic             is_inf,
        input logic             is_nan,
        input logic [MAG_W-1:0] mag_half
    );
        logic [MAG_W-1:0] rnd;
        logic [7:0]       neg;
        rnd = (mag_half + {{(MAG_W-1){1'b0}}, 1'b1}) >> 1;
        neg = 8'd0 - rnd[7:0];
        if (is_nan) begin
            round_saturate = {2'b10, 8'h00};
        end else if (is_inf) begin
            round_saturate = sign ? {2'b01, 8'h80} : {2'b01, 8'h7F};
        end else if (!sign) begin
            if (rnd > {{(MAG_W-8){1'b0}}, 8'd127}) begin
                round_saturate = {2'b01, 8'h7F};
            end else begin
                round_saturate = {2'b00, rnd[7:0]};
            end
        end else begin
            // A magnitude of exactly 128 is representable as 0x80.
            if (rnd > {{(MAG_W-8){1'b0}}, 8'd128}) begin
                round_saturate = {2'b01, 8'h80};
            end else begin
                round_saturate = {2'b00, neg};
            end
        end
    endfunction

    logic             valid1_r;
    logic             valid2_r;
    logic             ready1_s;
    logic             ready2_s;

    logic             sign_s;
    logic [4:0]       exp_s;
    logic [9:0]       man_s;
    logic             inf_s;
    logic             nan_s;
    int               shift_s;
    logic [MAG_W-1:0] mant_ext_s;
    logic [MAG_W-1:0] mag_s;

    logic             sign1_r;
    logic             inf1_r;
    logic             nan1_r;
    logic [MAG_W-1:0] mag1_r;

    logic [9:0]       conv_s;
    logic [7:0]       data2_r;

    // Elastic handshake: a stage can take new data when empty or draining.
    always_comb begin
        ready2_s = !valid2_r || m_axis_result_tready;
        ready1_s = !valid1_r || ready2_s;
    end

    assign s_axis_a_tready = ready1_s;

    // Stage 1 combinational: unpack fields and align the mantissa.
    always_comb begin
        sign_s     = s_axis_a_tdata[15];
        exp_s      = s_axis_a_tdata[14:10];
        man_s      = s_axis_a_tdata[9:0];
        inf_s      = (exp_s == 5'd31) && (man_s == 10'd0);
        nan_s      = (exp_s == 5'd31) && (man_s != 10'd0);
        shift_s    = int'(exp_s) + FRAC_BITS - SHIFT_OFFSET;
        mant_ext_s = {{(MAG_W-11){1'b0}}, 1'b1, man_s};
        if ((exp_s == 5'd0) || (exp_s == 5'd31)) begin
            // Zero/subnormal give 0; inf/NaN are resolved from the flags.
            mag_s = {MAG_W{1'b0}};
        end else if (shift_s >= 32'sd0) begin
            mag_s = mant_ext_s << shift_s;
        end else begin
            mag_s = mant_ext_s >> (-shift_s);
        end
    end

    // Stage 1 register: captures the aligned magnitude when the stage advances.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid1_r <= 1'b0;
            sign1_r  <= 1'b0;
            inf1_r   <= 1'b0;
            nan1_r   <= 1'b0;
            mag1_r   <= {MAG_W{1'b0}};
        end else if (ready1_s) begin
            valid1_r <= s_axis_a_tvalid;
            sign1_r  <= sign_s;
            inf1_r   <= inf_s;
            nan1_r   <= nan_s;
            mag1_r   <= mag_s;
        end
    end

    // Stage 2 combinational: round and saturate the stage 1 magnitude.
    always_comb begin
        conv_s = round_saturate(sign1_r, inf1_r, nan1_r, mag1_r);
    end

    // Stage 2 register: holds the result steady while downstream stalls.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid2_r <= 1'b0;
            data2_r  <= 8'h00;
        end else if (ready2_s) begin
            valid2_r <= valid1_r;
            data2_r  <= conv_s[7:0];
        end
    end

    assign m_axis_result_tvalid = valid2_r;
    assign m_axis_result_tdata  = data2_r;

`ifdef FLOAT_A_FIJO_STATUS_EN
    logic [1:0] status2_r;

    // Status flags advance in lockstep with their data beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            status2_r <= 2'b00;
        end else if (ready2_s) begin
            status2_r <= {conv_s[9], conv_s[8]};
        end
    end

    assign m_axis_status_tdata = status2_r;
`else
    logic unused_flags_s;
    assign unused_flags_s = ^conv_s[9:8];
`endif

endmodule

// File: tb/tb_float_a_fijo.sv
// -----------------------------------------------------------------------------
// tb_float_a_fijo: scoreboard bench for float_a_fijo (FRAC_BITS = 4).
// Accepted beats push a reference result computed with real arithmetic; a
// monitor process pops and compares each delivered result beat, and also
// checks reset state and output stability under backpressure.
// -----------------------------------------------------------------------------
module tb_float_a_fijo;

    localparam int FB = 4;

    logic        aclk;
    logic        areset;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
`ifdef FLOAT_A_FIJO_STATUS_EN
    logic [1:0]  m_status;
`endif

    float_a_fijo #(.FRAC_BITS(FB)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_a_tvalid      (s_tvalid),
        .s_axis_a_tready      (s_tready),
        .s_axis_a_tdata       (s_tdata),
        .m_axis_result_tvalid (m_tvalid),
        .m_axis_result_tready (m_tready),
        .m_axis_result_tdata  (m_tdata)
`ifdef FLOAT_A_FIJO_STATUS_EN
        ,
        .m_axis_status_tdata  (m_status)
`endif
    );

    typedef struct {
        logic [15:0] din;
        logic [7:0]  d;
        logic [1:0]  st;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   gap_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc = 0;
    bit   started = 0;
    bit   lat_tag = 0;
    bit   gap_rec = 0;

    // Clock generation.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Absolute time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: value = (-1)^s * 1.m * 2^(e-15) * 2^FB, rounded half away
    // from zero on the magnitude, then saturated. Returns {invalid, ovf, data}.
    function automatic logic [9:0] ref_model(input logic [15:0] x);
        int     e;
        int     m;
        real    mag;
        longint r;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 31 && m != 0) return {2'b10, 8'h00};
        if (e == 31) return x[15] ? {2'b01, 8'h80} : {2'b01, 8'h7F};
        if (e == 0) return {2'b00, 8'h00};
        mag = (1.0 + real'(m) / 1024.0) * (2.0 ** (real'(e) - 15.0 + real'(FB)));
        r = longint'($floor(mag + 0.5));
        if (!x[15]) begin
            if (r > 127) return {2'b01, 8'h7F};
            return {2'b00, 8'(r)};
        end
        if (r > 128) return {2'b01, 8'h80};
        return {2'b00, 8'(-r)};
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0: v = v;
            1, 2: v[14:10] = 5'($urandom_range(8, 23));
            default: begin
                case ($urandom_range(0, 7))
                    0: v = 16'h0000;
                    1: v = 16'h8000;
                    2: v = 16'h7C00;
                    3: v = 16'hFC00;
                    4: v = 16'h7E01;
                    5: v = 16'hC800;
                    6: v = 16'h57F0;
                    default: v = 16'hA800;
                endcase
            end
        endcase
        return v;
    endfunction

    // Monitor: scoreboard pop/compare, reset-state and stall-stability checks,
    // then scoreboard push for beats accepted at the coming edge.
    task automatic monitor();
        bit         rst_pending = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        exp_t       e;
        forever begin
            @(negedge aclk);
            cyc++;
            if (started) begin
                if (rst_pending) begin
                    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
                    check("rst_tdata", {24'd0, m_tdata}, 32'd0);
                    check("rst_tready", {31'd0, s_tready}, 32'd1);
`ifdef FLOAT_A_FIJO_STATUS_EN
                    check("rst_status", {30'd0, m_status}, 32'd0);
`endif
                end else if (prev_stall) begin
                    check("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
                    check("stall_tdata", {24'd0, m_tdata}, {24'd0, prev_data});
                end
                if (m_tvalid === 1'b1 && m_tready) begin
                    n_out++;
                    if (gap_rec) gap_q.push_back(cyc);
                    if (q.size() == 0) begin
                        check("unexpected_beat", {24'd0, m_tdata}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("data[%h]", e.din), {24'd0, m_tdata}, {24'd0, e.d});
`ifdef FLOAT_A_FIJO_STATUS_EN
                        check($sformatf("status[%h]", e.din), {30'd0, m_status}, {30'd0, e.st});
`endif
                        if (e.lat) check("latency", cyc - e.acc_cyc, 32'd2);
                    end
                end
            end
            if (areset) begin
                q.delete();
            end else if (s_tvalid && s_tready) begin
                e.din     = s_tdata;
                {e.st, e.d} = ref_model(s_tdata);
                e.acc_cyc = cyc;
                e.lat     = lat_tag;
                q.push_back(e);
            end
            prev_stall  = (m_tvalid === 1'b1) && !m_tready && !areset;
            prev_data   = m_tdata;
            rst_pending = areset;
        end
    endtask

    task automatic send(input logic [15:0] x);
        s_tvalid = 1'b1;
        s_tdata  = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (s_tready) begin
                @(posedge aclk);
                #1;
                s_tvalid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd1, 32'd0);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge aclk);
            #1;
        end
        repeat (3) @(posedge aclk);
        #1;
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] dir_vec [11];
        logic [15:0] rst_data;
        int          outs_before;
        bit          acc;

        dir_vec = '{16'h2C00, 16'h2800, 16'hA800, 16'h8000, 16'h4900, 16'h7C00,
                    16'hCC00, 16'hC800, 16'h7E00, 16'hFC00, 16'h0001};
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 16'h0000;
        m_tready = 1'b1;
        fork
            monitor();
        join_none

        repeat (2) @(posedge aclk);
        #1;
        started = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Back-to-back beats with latency measurement.
        lat_tag = 1'b1;
        send(16'h3C00);
        send(16'h4000);
        send(16'hC400);
        drain();
        lat_tag = 1'b0;

        // Rounding, sign, saturation and special values.
        foreach (dir_vec[i]) send(dir_vec[i]);
        drain();

        // Backpressure: two beats fill the pipe, the third stalls.
        m_tready = 1'b0;
        send(16'h3C00);
        send(16'h4000);
        s_tvalid = 1'b1;
        s_tdata  = 16'hC400;
        @(negedge aclk);
        check("bp_tready", {31'd0, s_tready}, 32'd0);
        repeat (3) @(negedge aclk);
        check("bp_tready_hold", {31'd0, s_tready}, 32'd0);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        gap_rec  = 1'b1;
        send(16'hC400);
        drain();
        gap_rec = 1'b0;
        check("bp_count", gap_q.size(), 32'd3);
        if (gap_q.size() == 3) begin
            check("bp_gap0", gap_q[1] - gap_q[0], 32'd1);
            check("bp_gap1", gap_q[2] - gap_q[1], 32'd1);
        end

        // Reset with two beats in flight: neither may appear.
        m_tready = 1'b0;
        rst_data = 16'h4500;
        send(rst_data);
        send(16'hC500);
        outs_before = n_out;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset   = 1'b0;
        m_tready = 1'b1;
        repeat (6) @(posedge aclk);
        #1;
        check("rst_discard", n_out - outs_before, 32'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (acc || !s_tvalid) begin
                if ($urandom_range(0, 3) != 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = rand_half();
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
